// File: rtl/mem_arbiter.sv
// Purpose : shares one single-ported, variable-latency memory between instruction fetch and data ports.
// Latency : request accepted in cycle N, memory responds in N+L, o_X_valid pulses in N+L+1 (next grant possible in N+L+1).
// Backpres: one transaction outstanding; o_X_ready only in IDLE with i_mem_ready; data has priority, fetch forced after a data streak.
//
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_imem_* / o_imem_*                fetch port: req/addr in, ready/valid/rdata out
//   i_dmem_* / o_dmem_*                data port: req/addr/wen/wdata/mask in, ready/valid/rdata out
//   o_mem_* / i_mem_*                  unified memory: req/addr/wen/wdata/mask out, ready/rvalid/rdata in
//   o_spurious                         sticky: a memory response arrived with nothing outstanding
module mem_arbiter #(
    parameter int unsigned DATA_STREAK_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_imem_req,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic        o_imem_valid,
    output logic [31:0] o_imem_rdata,

    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,

    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,

    output logic        o_spurious
);

    localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic [3:0] streak_nxt;
    logic       pend_wen;
    logic       streak_full;
    logic       grant_i;
    logic       grant_d;

    // The byte offset is dropped on purpose; alignment faults are the hart's business.
    logic       unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_imem_addr[1:0], i_dmem_addr[1:0]};

    // Data wins unless fetch has been passed over DATA_STREAK_MAX times in a row;
    // a lone data request wins even when the streak is full.
    always_comb begin
        streak_full = (streak == STREAK_MAX);
        grant_d     = i_dmem_req && (!streak_full || !i_imem_req);
        grant_i     = i_imem_req && !grant_d;
    end

    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        o_mem_req    = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = 32'd0;
        o_mem_mask   = 4'd0;
        o_imem_ready = 1'b0;
        o_dmem_ready = 1'b0;

        case (state)
            IDLE: begin
                o_mem_req = i_imem_req | i_dmem_req;
                if (grant_d) begin
                    o_mem_addr  = {i_dmem_addr[31:2], 2'b00};
                    o_mem_wen   = i_dmem_wen;
                    o_mem_wdata = i_dmem_wdata;
                    o_mem_mask  = i_dmem_mask;
                end else if (grant_i) begin
                    o_mem_addr  = {i_imem_addr[31:2], 2'b00};
                    o_mem_mask  = 4'b1111;
                end
                o_imem_ready = grant_i & i_mem_ready;
                o_dmem_ready = grant_d & i_mem_ready;

                if (o_imem_ready) begin
                    state_nxt = WAIT_I;
                end else if (o_dmem_ready) begin
                    state_nxt = WAIT_D;
                end

                // Streak only measures how long a waiting fetch has been passed over.
                if (!i_imem_req || o_imem_ready) begin
                    streak_nxt = 4'd0;
                end else if (o_dmem_ready && !streak_full) begin
                    streak_nxt = streak + 4'd1;
                end
            end
            WAIT_I, WAIT_D: begin
                if (i_mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            streak       <= 4'd0;
            pend_wen     <= 1'b0;
            o_imem_valid <= 1'b0;
            o_dmem_valid <= 1'b0;
            o_imem_rdata <= 32'd0;
            o_dmem_rdata <= 32'd0;
            o_spurious   <= 1'b0;
        end else begin
            state        <= state_nxt;
            streak       <= streak_nxt;
            o_imem_valid <= (state == WAIT_I) && i_mem_rvalid;
            o_dmem_valid <= (state == WAIT_D) && i_mem_rvalid;

            if (o_dmem_ready) begin
                pend_wen <= i_dmem_wen;
            end
            if ((state == WAIT_I) && i_mem_rvalid) begin
                o_imem_rdata <= i_mem_rdata;
            end
            // A store acknowledge carries no data; whatever memory drives is discarded.
            if ((state == WAIT_D) && i_mem_rvalid) begin
                o_dmem_rdata <= pend_wen ? 32'd0 : i_mem_rdata;
            end
            // Includes a response landing in the acceptance cycle, or one orphaned by reset.
            if ((state == IDLE) && i_mem_rvalid) begin
                o_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        i_imem_req;
    logic [31:0] i_imem_addr;
    logic        o_imem_ready, o_imem_valid;
    logic [31:0] o_imem_rdata;
    logic        i_dmem_req;
    logic [31:0] i_dmem_addr;
    logic        i_dmem_wen;
    logic [31:0] i_dmem_wdata;
    logic [3:0]  i_dmem_mask;
    logic        o_dmem_ready, o_dmem_valid;
    logic [31:0] o_dmem_rdata;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        mem_ready, mem_rvalid, inj_rvalid;
    logic [31:0] mem_rdata;
    logic        o_spurious;

    mem_arbiter #(.DATA_STREAK_MAX(MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_imem_req(i_imem_req), .i_imem_addr(i_imem_addr),
        .o_imem_ready(o_imem_ready), .o_imem_valid(o_imem_valid), .o_imem_rdata(o_imem_rdata),
        .i_dmem_req(i_dmem_req), .i_dmem_addr(i_dmem_addr), .i_dmem_wen(i_dmem_wen),
        .i_dmem_wdata(i_dmem_wdata), .i_dmem_mask(i_dmem_mask),
        .o_dmem_ready(o_dmem_ready), .o_dmem_valid(o_dmem_valid), .o_dmem_rdata(o_dmem_rdata),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid | inj_rvalid), .i_mem_rdata(mem_rdata),
        .o_spurious(o_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Memory environment controls: mode 0 random ready, 1 always ready, 2 never ready.
    int mode      = 1;
    int lat_min   = 1;
    int lat_max   = 1;
    bit drop_resp = 0;

    logic [31:0] env_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    typedef struct {
        bit          is_d;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state.
    bit busy     = 0;
    bit cur_d    = 0;
    int due      = 0;   // 1: fetch response due this cycle, 2: data response due
    int cnt      = 0;   // consecutive data grants while fetch kept waiting
    bit spur_exp = 0;

    function automatic logic [31:0] init_word(int unsigned a);
        return ((a * 32'h9E3779B1) ^ 32'h5A5A0000) | 32'h1;
    endfunction

    function automatic logic [31:0] mexp(logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic [31:0] env_rd(int unsigned a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: accepts via o_mem_*, answers after a random latency.
    initial begin
        int          pend;
        logic [31:0] pdat;
        int unsigned wa;
        logic [31:0] old;
        pend = 0;
        pdat = 0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0;
            end else if (o_mem_req && mem_ready && pend == 0) begin
                wa  = o_mem_addr[31:2];
                old = env_rd(wa);
                if (o_mem_wen) begin
                    env_mem[wa] = (old & ~mexp(o_mem_mask)) | (o_mem_wdata & mexp(o_mem_mask));
                    pdat = $urandom;
                end else begin
                    pdat = old;
                end
                if (!drop_resp) pend = $urandom_range(lat_max, lat_min);
            end
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pdat;
                end
            end
            mem_ready = (mode == 1) || (mode == 0 && $urandom_range(0, 9) < 7);
        end
    end

    // Monitor / scoreboard: arbitration rules checked every cycle, responses popped on valid.
    initial begin
        bit   d_win, i_win;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; due = 0; cnt = 0; spur_exp = 0;
                exp_q.delete();
                if (!i_imem_req && !i_dmem_req) begin
                    chk("rst_mem_req", {31'd0, o_mem_req}, 0);
                    chk("rst_mem_fields", o_mem_addr | o_mem_wdata | {27'd0, o_mem_wen, o_mem_mask}, 0);
                    chk("rst_ready", {30'd0, o_imem_ready, o_dmem_ready}, 0);
                    chk("rst_valid", {30'd0, o_imem_valid, o_dmem_valid}, 0);
                    chk("rst_imem_rdata", o_imem_rdata, 0);
                    chk("rst_dmem_rdata", o_dmem_rdata, 0);
                    chk("rst_spurious", {31'd0, o_spurious}, 0);
                end
            end else begin
                chk("imem_valid", {31'd0, o_imem_valid}, {31'd0, due == 1});
                chk("dmem_valid", {31'd0, o_dmem_valid}, {31'd0, due == 2});
                if (o_imem_valid || o_dmem_valid) begin
                    if (exp_q.size() == 0) begin
                        miss("resp_without_request");
                    end else begin
                        e = exp_q.pop_front();
                        if (o_imem_valid) begin
                            chk("imem_owner", {31'd0, e.is_d}, 0);
                            chk("imem_rdata", o_imem_rdata, e.dat);
                        end else begin
                            chk("dmem_owner", {31'd0, e.is_d}, 1);
                            chk("dmem_rdata", o_dmem_rdata, e.dat);
                        end
                    end
                end
                due = 0;
                chk("spurious", {31'd0, o_spurious}, {31'd0, spur_exp});

                if (busy) begin
                    chk("wait_mem_req", {31'd0, o_mem_req}, 0);
                    chk("wait_ready", {30'd0, o_imem_ready, o_dmem_ready}, 0);
                    chk("wait_mem_fields", o_mem_addr | o_mem_wdata | {27'd0, o_mem_wen, o_mem_mask}, 0);
                    if (mem_rvalid | inj_rvalid) begin
                        due  = cur_d ? 2 : 1;
                        busy = 0;
                    end
                end else begin
                    if (mem_rvalid | inj_rvalid) spur_exp = 1;
                    chk("mem_req", {31'd0, o_mem_req}, {31'd0, i_imem_req | i_dmem_req});
                    d_win = i_dmem_req && !(i_imem_req && cnt >= MAX);
                    i_win = i_imem_req && !d_win;
                    chk("imem_ready", {31'd0, o_imem_ready}, {31'd0, i_win && mem_ready});
                    chk("dmem_ready", {31'd0, o_dmem_ready}, {31'd0, d_win && mem_ready});
                    if (d_win) begin
                        chk("d_mem_addr", o_mem_addr, {i_dmem_addr[31:2], 2'b00});
                        chk("d_mem_wen", {31'd0, o_mem_wen}, {31'd0, i_dmem_wen});
                        chk("d_mem_wdata", o_mem_wdata, i_dmem_wdata);
                        chk("d_mem_mask", {28'd0, o_mem_mask}, {28'd0, i_dmem_mask});
                    end else if (i_win) begin
                        chk("i_mem_addr", o_mem_addr, {i_imem_addr[31:2], 2'b00});
                        chk("i_mem_ctl", {27'd0, o_mem_wen, o_mem_mask}, 32'h0000000F);
                        chk("i_mem_wdata", o_mem_wdata, 0);
                    end
                    if (i_win && mem_ready) begin
                        exp_q.push_back('{is_d: 1'b0, dat: ref_rd(i_imem_addr[31:2])});
                        busy = 1; cur_d = 0; cnt = 0;
                    end else if (d_win && mem_ready) begin
                        if (i_dmem_wen) begin
                            ref_mem[i_dmem_addr[31:2]] = (ref_rd(i_dmem_addr[31:2]) & ~mexp(i_dmem_mask))
                                                       | (i_dmem_wdata & mexp(i_dmem_mask));
                            exp_q.push_back('{is_d: 1'b1, dat: 32'd0});
                        end else begin
                            exp_q.push_back('{is_d: 1'b1, dat: ref_rd(i_dmem_addr[31:2])});
                        end
                        busy = 1; cur_d = 1;
                        if (i_imem_req && cnt < MAX) cnt++;
                    end
                    if (!i_imem_req) cnt = 0;
                end
            end
        end
    end

    task automatic wait_rdy(input bit is_d, input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(is_d ? o_dmem_ready : o_imem_ready) && t < 500);
        if (!(is_d ? o_dmem_ready : o_imem_ready)) miss(name);
    endtask

    task automatic idle_wait();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || due != 0 || busy) && t < 500);
        if (t >= 500) miss("drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic data_xfer(input logic [31:0] a, input bit w, input logic [31:0] wd, input logic [3:0] m);
        tick();
        i_dmem_req = 1; i_dmem_addr = a; i_dmem_wen = w; i_dmem_wdata = wd; i_dmem_mask = m;
        wait_rdy(1, "data_xfer_ready");
        tick();
        i_dmem_req = 0;
    endtask

    task automatic fetch_drv(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
            i_imem_req  = 1;
            i_imem_addr = $urandom_range(0, 255);
            wait_rdy(0, "rand_fetch_ready");
            tick();
            i_imem_req = 0;
        end
    endtask

    task automatic data_drv(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) tick();
            i_dmem_req   = 1;
            i_dmem_addr  = $urandom_range(0, 255);
            i_dmem_wen   = $urandom_range(0, 1);
            i_dmem_wdata = $urandom;
            i_dmem_mask  = i_dmem_wen ? 4'($urandom_range(1, 15)) : 4'hF;
            wait_rdy(1, "rand_data_ready");
            tick();
            i_dmem_req = 0;
        end
    endtask

    initial begin
        #600000;
        miss("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int  got_n, t, c;
        bit  fetch_acc;
        rst_n = 0; inj_rvalid = 0;
        i_imem_req = 0; i_imem_addr = 0;
        i_dmem_req = 0; i_dmem_addr = 0; i_dmem_wen = 0; i_dmem_wdata = 0; i_dmem_mask = 0;
        env_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1;
        @(negedge clk);

        // Lone fetch, L=1.
        tick();
        i_imem_req = 1; i_imem_addr = 32'h103;
        @(negedge clk);
        chk("lone_mem_addr", o_mem_addr, 32'h100);
        chk("lone_mem_mask", {28'd0, o_mem_mask}, 32'hF);
        chk("lone_ready", {31'd0, o_imem_ready}, 1);
        tick();
        i_imem_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("lone_valid_c2", {31'd0, o_imem_valid}, 1);
        chk("lone_rdata_c2", o_imem_rdata, 32'hDEADBEEF);
        idle_wait();

        // Both requests held: MAX data grants, then fetch, then data again.
        tick();
        i_imem_req = 1; i_imem_addr = 32'h20;
        i_dmem_req = 1; i_dmem_addr = 32'h10; i_dmem_wen = 0; i_dmem_mask = 4'hF; i_dmem_wdata = 0;
        got_n = 0; t = 0;
        while (got_n < MAX + 2 && t < 200) begin
            @(negedge clk);
            t++;
            fetch_acc = o_imem_ready;
            if (o_imem_ready || o_dmem_ready) begin
                chk($sformatf("grant_order_%0d", got_n), {31'd0, o_dmem_ready}, {31'd0, got_n != MAX});
                got_n++;
            end
            tick();
            if (fetch_acc) i_imem_req = 0;
        end
        if (got_n < MAX + 2) miss("grant_order_timeout");
        i_dmem_req = 0;
        idle_wait();

        // Store byte after a load so the zeroing of rdata is visible.
        data_xfer(32'h2000, 0, 0, 4'hF);
        idle_wait();
        tick();
        i_dmem_req = 1; i_dmem_addr = 32'h2003; i_dmem_wen = 1; i_dmem_mask = 4'b1000; i_dmem_wdata = 32'hAB000000;
        @(negedge clk);
        chk("store_wen", {31'd0, o_mem_wen}, 1);
        chk("store_addr", o_mem_addr, 32'h2000);
        chk("store_mask", {28'd0, o_mem_mask}, 32'h8);
        chk("store_ready", {31'd0, o_dmem_ready}, 1);
        tick();
        i_dmem_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("store_valid", {31'd0, o_dmem_valid}, 1);
        chk("store_rdata", o_dmem_rdata, 0);
        idle_wait();

        // Memory back-pressure for three cycles.
        mode = 2;
        tick();
        i_imem_req = 1; i_imem_addr = 32'h3456;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_no_ready_%0d", k), {31'd0, o_imem_ready}, 0);
            chk($sformatf("bp_addr_%0d", k), o_mem_addr, 32'h3454);
            if (k == 2) mode = 1;
            else tick();
        end
        tick();
        @(negedge clk);
        chk("bp_accept_c3", {31'd0, o_imem_ready}, 1);
        tick();
        i_imem_req = 0;
        idle_wait();

        // L=5: data request raised during WAIT_I waits for the fetch to finish.
        lat_min = 5; lat_max = 5;
        tick();
        i_imem_req = 1; i_imem_addr = 32'h44;
        @(negedge clk);
        chk("l5_fetch_accept", {31'd0, o_imem_ready}, 1);
        tick();
        i_imem_req = 0;
        i_dmem_req = 1; i_dmem_addr = 32'h48; i_dmem_wen = 0; i_dmem_mask = 4'hF;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!o_dmem_ready && c < 50);
        chk("l5_data_grant_cycle", c, 6);
        chk("l5_ivalid_with_grant", {31'd0, o_imem_valid}, 1);
        tick();
        i_dmem_req = 0;
        idle_wait();
        lat_min = 1; lat_max = 1;

        // Async reset while a load is outstanding, then a late response.
        drop_resp = 1;
        tick();
        i_dmem_req = 1; i_dmem_addr = 32'h40; i_dmem_wen = 0; i_dmem_mask = 4'hF;
        @(negedge clk);
        chk("rst_tx_accept", {31'd0, o_dmem_ready}, 1);
        tick();
        i_dmem_req = 0;
        @(posedge clk);
        #3;
        rst_n = 0;
        @(negedge clk);
        chk("rst_mid_mem_req", {31'd0, o_mem_req}, 0);
        chk("rst_mid_imem_rdata", o_imem_rdata, 0);
        chk("rst_mid_dmem_rdata", o_dmem_rdata, 0);
        tick();
        tick();
        rst_n = 1;
        drop_resp = 0;
        tick();
        inj_rvalid = 1;
        tick();
        inj_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid_spurious", {31'd0, o_spurious}, 1);
        chk("late_rvalid_no_dvalid", {31'd0, o_dmem_valid}, 0);
        idle_wait();

        // Randomized traffic against the scoreboard.
        mode = 0; lat_min = 1; lat_max = 6;
        tick();
        fork
            fetch_drv(200);
            data_drv(200);
        join
        idle_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single unified, single-ported, variable-latency memory between the hart's instruction-fetch port and its data (load/store) port. Each port has a request/ready/valid handshake. Requests are arbitrated with data priority and a bounded fetch-starvation limit, and exactly one transaction is outstanding at a time. The block sits between the hart and the unified memory model. It replaces the separate combinational imem/dmem ports once the hart is pipelined with stall support.

## Interface
- `DATA_STREAK_MAX`, default 4: number of consecutive data grants allowed while fetch is waiting before fetch is forced to win. Legal range is 1..15.
- `i_clk` input 1: clock. All state changes on the rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_imem_req` input 1: fetch request. Held with its address until `o_imem_ready`.
- `i_imem_addr` input 32: fetch byte address.
- `o_imem_ready` output 1: fetch request accepted this cycle.
- `o_imem_valid` output 1: fetch response valid, one-cycle pulse.
- `o_imem_rdata` output 32: fetch response word.
- `i_dmem_req` input 1: data request. Held with its address, wen, wdata and mask until `o_dmem_ready`.
- `i_dmem_addr` input 32: data byte address.
- `i_dmem_wen` input 1: 1 = store, 0 = load.
- `i_dmem_wdata` input 32: store data, already lane-shifted.
- `i_dmem_mask` input 4: byte-lane mask.
- `o_dmem_ready` output 1: data request accepted this cycle.
- `o_dmem_valid` output 1: data response or store acknowledge, one-cycle pulse.
- `o_dmem_rdata` output 32: load response word. 0 for stores.
- `o_mem_req` output 1: request to memory.
- `o_mem_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `o_mem_wen` output 1: memory write enable.
- `o_mem_wdata` output 32: memory write data.
- `o_mem_mask` output 4: memory byte mask. `4'b1111` for fetch.
- `i_mem_ready` input 1: memory accepts the request this cycle.
- `i_mem_rvalid` input 1: memory response. Pulsed for both reads and write acknowledges.
- `i_mem_rdata` input 32: memory read data.
- `o_spurious` output 1: sticky flag. Set when `i_mem_rvalid` arrives with no transaction outstanding.

## Operation
- The state machine has three states:
  - IDLE: arbitrate and drive the winner onto `o_mem_*`.
  - WAIT_I: a fetch is outstanding.
  - WAIT_D: a data access is outstanding.
- Grant selection in IDLE is combinational:
  - data wins if `i_dmem_req` is high and `streak != DATA_STREAK_MAX`;
  - otherwise fetch wins if `i_imem_req` is high;
  - otherwise data wins if `i_dmem_req` is high (a lone data request always wins).
- Memory drive from IDLE:
  - `o_mem_req = i_imem_req | i_dmem_req`.
  - The winner's fields are driven on `o_mem_*`.
  - A fetch drives `o_mem_wen=0`, `o_mem_mask=4'b1111` and `o_mem_wdata=0`.
- Acceptance: `o_X_ready = IDLE & grant_X & i_mem_ready`. On acceptance the state moves to WAIT_I or WAIT_D.
- WAIT states:
  - `o_mem_req=0` and all `o_mem_*` fields are 0.
  - `o_*_ready=0`.
  - `i_mem_rvalid` captures the response into a register, pulses the owner's `o_X_valid` on the next cycle and returns to IDLE.
- Response data:
  - `o_imem_rdata` and `o_dmem_rdata` are registered and hold their last value between pulses.
  - A store ack loads 0 into `o_dmem_rdata`.
- Streak counter (4-bit):
  - On a data grant while `i_imem_req` is high: increment, saturating at `DATA_STREAK_MAX`.
  - Cleared on a fetch grant.
  - Cleared in any IDLE cycle with `i_imem_req` low.
- Spurious responses: `i_mem_rvalid` in IDLE is ignored for data purposes and sets `o_spurious`. Only reset clears it.
- Address handling: the low address bits are dropped without checking. Misalignment trapping belongs to the hart.

## Timing
- Reset (`i_rst_n` low, asynchronous):
  - state goes to IDLE;
  - streak, `o_imem_valid`, `o_dmem_valid`, both rdata registers and `o_spurious` go to 0.
  - `o_mem_*` and `o_*_ready` then follow the combinational IDLE rules, so all are 0 when no request is present.
- Reset mid-transaction: the outstanding response is dropped. A late `i_mem_rvalid` after release sets `o_spurious`.
- Latency:
  - request accepted in cycle N;
  - memory responds in cycle N+L (L ≥ 1);
  - `o_X_valid` is high in cycle N+L+1;
  - the next grant is possible in cycle N+L+1.
- `i_mem_rvalid` in the same cycle as acceptance (combinational response) is not supported. The arbiter ignores it in IDLE and it sets `o_spurious`.
- Only one `o_X_ready` is high in any cycle. `o_imem_valid` and `o_dmem_valid` are never high together.
- Requesters may not drop or change a request before ready. The arbiter does not check this.

## Test plan
- Lone fetch, memory L=1:
  - stimulus: `i_imem_addr=0x103`, `i_mem_ready=1`, rdata `0xDEADBEEF`;
  - required: `o_mem_addr=0x100` and mask `1111` in cycle 0; `o_imem_ready` in cycle 0; `o_imem_valid=1` with `0xDEADBEEF` in cycle 2.
- Simultaneous requests, both held, `DATA_STREAK_MAX=4`, L=1: required grant order is D,D,D,D,I, then D resumes. Streak reads 0 after the fetch grant.
- Store byte:
  - stimulus: addr `0x2003`, mask `1000`, wdata `0xAB000000`;
  - required: `o_mem_wen=1`, addr `0x2000`; `o_dmem_valid` one cycle after the ack with rdata `0`.
- Memory back-pressure: `i_mem_ready=0` for 3 cycles with a fetch pending. Required: no ready, request fields stable; accept in cycle 3.
- Async reset asserted in WAIT_D, released, then `i_mem_rvalid` pulsed. Required: all outputs 0 during reset; no `o_dmem_valid`; `o_spurious=1`.
- L=5 latency: a data request while WAIT_I is active is not granted until the cycle after `o_imem_valid`'s source rvalid.
